// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID verify master.
// Word offsets match the system-ID slave register map.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic SYSID_WORD_ID = 1'b0;
    localparam logic SYSID_WORD_TS = 1'b1;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sysid_read_attempt.sv
// Single-word Avalon-MM read with a per-attempt timeout and retry budget.
// The caller owns sequencing; this block reports accept/valid/retry/fail.
module sysid_read_attempt
    import sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_req,
    input  logic        in_wait,
    input  logic        word,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        avm_read,
    output logic        avm_address,
    output logic        accepted,
    output logic        valid,
    output logic [31:0] data,
    output logic        retry,
    output logic        fail
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RMAX = 4'(MAX_RETRIES);

    logic [CW-1:0] cycles;
    logic [3:0]    retries;
    logic          active;
    logic          expired;
    logic          can_retry;

    assign active      = in_req | in_wait;
    assign avm_read    = in_req;
    assign avm_address = word;
    assign accepted    = in_req & ~avm_waitrequest;
    assign valid       = in_wait & avm_readdatavalid;
    assign data        = avm_readdata;

    // Data arriving on the last cycle of the window still counts.
    assign expired   = active & (cycles == LAST) & ~valid;
    assign can_retry = retries < RMAX;
    assign retry     = expired & can_retry;
    assign fail      = expired & ~can_retry;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycles  <= '0;
            retries <= '0;
        end else begin
            if (!active || expired || valid)
                cycles <= '0;
            else
                cycles <= cycles + 1'b1;

            if (!active || valid)
                retries <= '0;
            else if (retry)
                retries <= retries + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_verify_master.sv
// Reads system ID and build timestamp after reset or on request and
// flags a mismatched image before the datapath is enabled.
module sysid_verify_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1424903334,
    parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      state;
    state_t      next;
    logic        auto_pending;
    logic        in_req;
    logic        in_wait;
    logic        word;
    logic        accepted;
    logic        valid;
    logic        retry;
    logic        fail;
    logic        launch;
    logic [31:0] data;

    assign in_req  = (state == ST_ID_REQ) || (state == ST_TS_REQ);
    assign in_wait = (state == ST_ID_WAIT) || (state == ST_TS_WAIT);
    assign word    = ((state == ST_TS_REQ) || (state == ST_TS_WAIT))
                     ? SYSID_WORD_TS : SYSID_WORD_ID;

    assign done        = (state == ST_DONE) || (state == ST_ERROR);
    assign timeout_err = (state == ST_ERROR);
    assign busy        = (state != ST_IDLE) && !done;

    assign launch = ((state == ST_IDLE) && (auto_pending || start))
                    || (done && start);

    sysid_read_attempt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_attempt (
        .clock             (clock),
        .reset_n           (reset_n),
        .in_req            (in_req),
        .in_wait           (in_wait),
        .word              (word),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .avm_read          (avm_read),
        .avm_address       (avm_address),
        .accepted          (accepted),
        .valid             (valid),
        .data              (data),
        .retry             (retry),
        .fail              (fail)
    );

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE:
                if (auto_pending || start) next = ST_ID_REQ;
            ST_ID_REQ:
                if (fail)          next = ST_ERROR;
                else if (retry)    next = ST_ID_REQ;
                else if (accepted) next = ST_ID_WAIT;
            ST_ID_WAIT:
                if (valid)         next = ST_TS_REQ;
                else if (fail)     next = ST_ERROR;
                else if (retry)    next = ST_ID_REQ;
            ST_TS_REQ:
                if (fail)          next = ST_ERROR;
                else if (retry)    next = ST_TS_REQ;
                else if (accepted) next = ST_TS_WAIT;
            ST_TS_WAIT:
                if (valid)         next = ST_CHECK;
                else if (fail)     next = ST_ERROR;
                else if (retry)    next = ST_TS_REQ;
            ST_CHECK:
                next = ST_DONE;
            ST_DONE, ST_ERROR:
                if (start) next = ST_ID_REQ;
            default:
                next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            auto_pending <= 1'b1;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
        end else begin
            state <= next;
            if (state == ST_IDLE)
                auto_pending <= 1'b0;
            if (launch) begin
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
            end
            if ((state == ST_ID_WAIT) && valid)
                id_value <= data;
            if ((state == ST_TS_WAIT) && valid)
                ts_value <= data;
            if (state == ST_CHECK) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: doc/sysid_verify_master.md
Name: sysid_verify_master

Overview:
Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata. After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), latches both and compares them against build-time expected values. It exports pass/fail/timeout status to the boot controller and LEDs, so a mismatched FPGA image is flagged before the MIDI datapath is enabled.

Parameters:
EXPECTED_ID, 32'd0, expected system ID (word 0).
EXPECTED_TIMESTAMP, 32'd1424903334, expected build timestamp (word 1).
TIMEOUT_CYCLES, 1024, max cycles per read attempt (request plus data wait), >=2.
MAX_RETRIES, 3, extra attempts per word after a timeout, 0..15.

Ports:
clock  in  1  system clock; single clock domain.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; re-runs the check when idle/done/error.
avm_address  out  1  word select: 0 = ID, 1 = timestamp.
avm_read  out  1  read request.
avm_waitrequest  in  1  fabric stall; request is held while this is high.
avm_readdatavalid  in  1  readdata qualifier.
avm_readdata  in  32  returned word.
busy  out  1  check in progress.
done  out  1  level; check finished (pass or fail); cleared on new start.
id_ok  out  1  latched ID == EXPECTED_ID; valid when done.
ts_ok  out  1  latched timestamp == EXPECTED_TIMESTAMP; valid when done.
timeout_err  out  1  level; retries exhausted on either word.
id_value  out  32  last captured ID.
ts_value  out  32  last captured timestamp.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, auto_pending=1, all outputs 0 (avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value); timeout and retry counters 0.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE, ERROR.
- IDLE: if auto_pending or start -> ID_REQ; clear auto_pending; clear done/id_ok/ts_ok/timeout_err; reset the retry counter.
- xx_REQ: avm_read=1, avm_address constant (0 for ID, 1 for TS). Accepted on an edge where avm_waitrequest=0, then -> xx_WAIT with avm_read=0 next cycle. Address and read are stable while waitrequest is high.
- xx_WAIT: on avm_readdatavalid, capture avm_readdata into id_value/ts_value. ID_WAIT -> TS_REQ (retry counter cleared); TS_WAIT -> CHECK.
- avm_readdatavalid outside an xx_WAIT state is ignored (late data from a timed-out attempt is not captured).
- Timeout: a counter runs from REQ entry through WAIT. When it reaches TIMEOUT_CYCLES-1 without data:
  - if retries < MAX_RETRIES, increment retries and go back to the same REQ;
  - otherwise -> ERROR.
- CHECK (1 cycle): register id_ok and ts_ok from equality compares -> DONE.
- DONE: done=1, busy=0. start -> IDLE path (re-run begins ID_REQ the next cycle).
- ERROR: timeout_err=1, done=1, id_ok=ts_ok=0. start re-runs the check.
- busy=1 in every state except IDLE, DONE and ERROR. start is ignored while busy.
- Latency, zero-wait fabric with readdatavalid one cycle after acceptance:
  - reset release = cycle 0; ID_REQ at cycle 1; ID_WAIT/capture at cycle 2;
  - TS_REQ at cycle 3; TS_WAIT/capture at cycle 4; CHECK at cycle 5;
  - done=1 from cycle 6.
- Reset asserted mid-operation: immediate return to reset values; avm_read drops asynchronously. After release, auto check runs again.
- start coincident with reset deassert: covered by auto_pending; only a single run occurs.

Decomposition:
- Shared package sysid_pkg: state enum type; word-offset constants SYSID_WORD_ID=0, SYSID_WORD_TS=1; DEFAULT_TIMEOUT.
- One natural sub-module, sysid_read_attempt: single-word Avalon read with timeout and retry, returning data/valid/fail. The top FSM instantiates it once and sequences the two words.

Test Plan:
- Zero-wait slave returning 0 / 1424903334 -> done=1 at cycle 6, id_ok=1, ts_ok=1, timeout_err=0, busy 1 on cycles 1-5.
- Slave returns timestamp 1424903335 -> done=1, id_ok=1, ts_ok=0, ts_value=1424903335.
- waitrequest high 5 cycles on the ID read -> avm_read/avm_address held stable all 5 cycles; single capture; pass.
- readdatavalid never asserted, TIMEOUT_CYCLES=8, MAX_RETRIES=1 -> exactly 2 ID_REQ attempts; ERROR, timeout_err=1, done=1 after 16 cycles.
- First ID attempt times out, valid arrives during the retry -> pass. A stray readdatavalid in IDLE/DONE leaves id_value unchanged.
- reset_n low during TS_WAIT -> all outputs 0 asynchronously. After release a full check reruns; start pulsed during busy has no effect.
